retire_trace_buffer: RTL and testbench

Synthesizable writeback trace buffer for the pipelined MIPS core. It replaces per-instruction bench printing of registers and data memory with on-chip capture. Each cycle it records GPR writes, FPR writes (e.g. lwc1 results) and data-memory stores as tagged entries in a parametrised circular buffer, stamped with a cycle count. It optionally halts capture after a programmed cycle budget. It sits beside the WB and MEM stages and is drained through a show-ahead pop port by a bench or a debug host.

---
 rtl/retire_trace_buffer.sv | 167 ++++++++++++++++
 tb/tb_retire_trace_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// Writeback/store trace buffer: captures GPR, FPR and store events into a circular buffer with cycle stamps.
// Optional cycle-budget halt is compiled in with `define RTRACE_HALT_EN.
module retire_trace_buffer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int CYC_W       = 16,
  parameter int WRAP        = 0,
  parameter int STOP_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       gpr_we,
  input  logic [4:0]                 gpr_idx,
  input  logic [DATA_W-1:0]          gpr_data,
  input  logic                       fpr_we,
  input  logic [4:0]                 fpr_idx,
  input  logic [DATA_W-1:0]          fpr_data,
  input  logic                       mem_we,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [1:0]                 rd_kind,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [CYC_W-1:0]           rd_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic int sat_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int inc);
    return PTR_W'(int'(p) + inc);
  endfunction

  logic [1:0]        kind_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [CYC_W-1:0]  cyc_mem  [DEPTH];

  logic [PTR_W-1:0] rptr, wptr;
  logic [CNT_W-1:0] cnt;
  logic [CYC_W-1:0] cyc;
  logic             ovf;
  logic             halt_r;

  logic              pop;
  logic [2:0]        ev_we;
  logic [1:0]        src_kind [3];
  logic [ADDR_W-1:0] src_addr [3];
  logic [DATA_W-1:0] src_data [3];
  logic [1:0]        ev_kind  [3];
  logic [ADDR_W-1:0] ev_addr  [3];
  logic [DATA_W-1:0] ev_data  [3];
  int                n_ev, n_free, n_store, n_drop, n_adv, cnt_nx;

  assign rd_valid = (cnt != '0);
  assign pop      = rd_en & rd_valid;
  assign ev_we    = {mem_we, fpr_we, gpr_we} & {3{en & ~halt_r}};

  assign src_kind[0] = 2'd0;
  assign src_kind[1] = 2'd1;
  assign src_kind[2] = 2'd2;
  assign src_addr[0] = ADDR_W'(gpr_idx);
  assign src_addr[1] = ADDR_W'(fpr_idx);
  assign src_addr[2] = mem_addr;
  assign src_data[0] = gpr_data;
  assign src_data[1] = fpr_data;
  assign src_data[2] = mem_data;

  // Compact valid events into consecutive slots in GPR, FPR, MEM priority order.
  always_comb begin
    n_ev = 0;
    for (int j = 0; j < 3; j++) begin
      ev_kind[j] = '0;
      ev_addr[j] = '0;
      ev_data[j] = '0;
    end
    for (int j = 0; j < 3; j++) begin
      if (ev_we[j]) begin
        ev_kind[n_ev] = src_kind[j];
        ev_addr[n_ev] = src_addr[j];
        ev_data[n_ev] = src_data[j];
        n_ev = n_ev + 1;
      end
    end
    n_free = DEPTH - int'(cnt) + int'(pop);
    if (WRAP != 0) begin
      n_store = n_ev;
      n_drop  = (n_ev > n_free) ? (n_ev - n_free) : 0;
      n_adv   = int'(pop) + n_drop;
      cnt_nx  = int'(cnt) - int'(pop) + n_store - n_drop;
    end else begin
      n_store = sat_min(n_ev, n_free);
      n_drop  = n_ev - n_store;
      n_adv   = int'(pop);
      cnt_nx  = int'(cnt) - int'(pop) + n_store;
    end
  end

  // Entry storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (j < n_store) begin
        kind_mem[ptr_add(wptr, j)] <= ev_kind[j];
        addr_mem[ptr_add(wptr, j)] <= ev_addr[j];
        data_mem[ptr_add(wptr, j)] <= ev_data[j];
        cyc_mem[ptr_add(wptr, j)]  <= cyc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      rptr <= ptr_add(rptr, n_adv);
      wptr <= ptr_add(wptr, n_store);
      cnt  <= CNT_W'(cnt_nx);
      if (n_drop != 0) ovf <= 1'b1;
    end
  end

`ifdef RTRACE_HALT_EN
  logic [CYC_W-1:0] cyc_inc;
  assign cyc_inc = cyc + 1'b1;

  // Counter and capture freeze on the edge that reaches the budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    <= '0;
      halt_r <= 1'b0;
    end else if (!halt_r) begin
      cyc <= cyc_inc;
      if (STOP_CYCLES != 0 && cyc_inc == CYC_W'(STOP_CYCLES)) halt_r <= 1'b1;
    end
  end
`else
  assign halt_r = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 1'b1;
  end
`endif

  assign rd_kind  = rd_valid ? kind_mem[rptr] : '0;
  assign rd_addr  = rd_valid ? addr_mem[rptr] : '0;
  assign rd_data  = rd_valid ? data_mem[rptr] : '0;
  assign rd_cycle = rd_valid ? cyc_mem[rptr]  : '0;
  assign count    = cnt;
  assign overflow = ovf;
  assign halted   = halt_r;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: three instances (stop-when-full, overwrite, deep with cycle budget)
// share stimulus; a queue model per instance predicts every head entry and status output.
module tb_retire_trace_buffer;

`ifdef RTRACE_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, gpr_we, fpr_we, mem_we, rd_en;
  logic [4:0]  gpr_idx, fpr_idx;
  logic [31:0] gpr_data, fpr_data, mem_addr, mem_data;

  logic        v0, v1, v2, o0, o1, o2, h0, h1, h2;
  logic [1:0]  k0, k1, k2;
  logic [31:0] a0, a1, a2, d0, d1, d2;
  logic [15:0] c0, c1, c2;
  logic [2:0]  n0, n1;
  logic [4:0]  n2;

  retire_trace_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .CYC_W(16), .WRAP(0), .STOP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .gpr_we(gpr_we), .gpr_idx(gpr_idx), .gpr_data(gpr_data),
    .fpr_we(fpr_we), .fpr_idx(fpr_idx), .fpr_data(fpr_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .rd_en(rd_en), .rd_valid(v0), .rd_kind(k0), .rd_addr(a0), .rd_data(d0), .rd_cycle(c0),
    .count(n0), .overflow(o0), .halted(h0));

  retire_trace_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .CYC_W(16), .WRAP(1), .STOP_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .gpr_we(gpr_we), .gpr_idx(gpr_idx), .gpr_data(gpr_data),
    .fpr_we(fpr_we), .fpr_idx(fpr_idx), .fpr_data(fpr_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .rd_en(rd_en), .rd_valid(v1), .rd_kind(k1), .rd_addr(a1), .rd_data(d1), .rd_cycle(c1),
    .count(n1), .overflow(o1), .halted(h1));

  retire_trace_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .CYC_W(16), .WRAP(0), .STOP_CYCLES(6)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .gpr_we(gpr_we), .gpr_idx(gpr_idx), .gpr_data(gpr_data),
    .fpr_we(fpr_we), .fpr_idx(fpr_idx), .fpr_data(fpr_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .rd_en(rd_en), .rd_valid(v2), .rd_kind(k2), .rd_addr(a2), .rd_data(d2), .rd_cycle(c2),
    .count(n2), .overflow(o2), .halted(h2));

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] cyc;
  } ent_t;

  typedef struct {
    bit          g, f, m, rd;
    logic [4:0]  gi;
    logic [31:0] gd;
    logic [4:0]  fi;
    logic [31:0] fd;
    logic [31:0] ma, md;
    int          cnt0, cnt1;
    bit          ovf0, ovf1;
  } vec_t;

  ent_t sb [3][$];
  int   depth [3] = '{4, 4, 16};
  bit   wrapm [3] = '{1'b0, 1'b1, 1'b0};
  int   stopc [3] = '{0, 0, 6};
  int   mcyc  [3];
  bit   mhalt [3];
  bit   movf  [3];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk_ent(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d, input int cy);
    ent_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.cyc  = cy[15:0];
    return e;
  endfunction

  // Queue model of one clock edge for every instance; call with inputs stable, before the edge.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      ent_t ev[$];
      bit   act;
      act = en && !mhalt[i];
      if (act && gpr_we) ev.push_back(mk_ent(2'd0, {27'd0, gpr_idx}, gpr_data, mcyc[i]));
      if (act && fpr_we) ev.push_back(mk_ent(2'd1, {27'd0, fpr_idx}, fpr_data, mcyc[i]));
      if (act && mem_we) ev.push_back(mk_ent(2'd2, mem_addr, mem_data, mcyc[i]));
      if (rd_en && sb[i].size() > 0) void'(sb[i].pop_front());
      foreach (ev[j]) begin
        if (sb[i].size() < depth[i]) sb[i].push_back(ev[j]);
        else begin
          movf[i] = 1'b1;
          if (wrapm[i]) begin
            void'(sb[i].pop_front());
            sb[i].push_back(ev[j]);
          end
        end
      end
      if (!mhalt[i]) begin
        mcyc[i] = (mcyc[i] + 1) % 65536;
        if (HALT_EN && stopc[i] != 0 && mcyc[i] == stopc[i]) mhalt[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic v, o, h;
      logic [1:0] k;
      logic [31:0] a, d;
      logic [15:0] c;
      int n;
      ent_t e;
      case (i)
        0: begin v = v0; o = o0; h = h0; k = k0; a = a0; d = d0; c = c0; n = int'(n0); end
        1: begin v = v1; o = o1; h = h1; k = k1; a = a1; d = d1; c = c1; n = int'(n1); end
        default: begin v = v2; o = o2; h = h2; k = k2; a = a2; d = d2; c = c2; n = int'(n2); end
      endcase
      e = mk_ent(2'd0, 32'd0, 32'd0, 0);
      if (sb[i].size() > 0) e = sb[i][0];
      chk($sformatf("u%0d count", i), 64'(n), 64'(sb[i].size()));
      chk($sformatf("u%0d rd_valid", i), 64'(v), 64'(sb[i].size() > 0));
      chk($sformatf("u%0d rd_kind", i), 64'(k), 64'(e.kind));
      chk($sformatf("u%0d rd_addr", i), 64'(a), 64'(e.addr));
      chk($sformatf("u%0d rd_data", i), 64'(d), 64'(e.data));
      chk($sformatf("u%0d rd_cycle", i), 64'(c), 64'(e.cyc));
      chk($sformatf("u%0d overflow", i), 64'(o), 64'(movf[i]));
      chk($sformatf("u%0d halted", i), 64'(h), 64'(mhalt[i]));
    end
  endtask

  task automatic set_in(input bit g, input bit f, input bit m, input bit rd,
                        input logic [4:0] gi, input logic [31:0] gd,
                        input logic [4:0] fi, input logic [31:0] fd,
                        input logic [31:0] ma, input logic [31:0] md);
    gpr_we = g; fpr_we = f; mem_we = m; rd_en = rd;
    gpr_idx = gi; gpr_data = gd; fpr_idx = fi; fpr_data = fd;
    mem_addr = ma; mem_data = md;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1;
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      sb[i].delete();
      mcyc[i] = 0;
      mhalt[i] = 1'b0;
      movf[i] = 1'b0;
    end
    #2;
    check_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input bit g, input bit f, input bit m, input bit rd,
                              input logic [4:0] gi, input logic [31:0] gd,
                              input logic [4:0] fi, input logic [31:0] fd,
                              input logic [31:0] ma, input logic [31:0] md,
                              input int e0, input int e1, input bit f0, input bit f1);
    vec_t t;
    t.g = g; t.f = f; t.m = m; t.rd = rd;
    t.gi = gi; t.gd = gd; t.fi = fi; t.fd = fd; t.ma = ma; t.md = md;
    t.cnt0 = e0; t.cnt1 = e1; t.ovf0 = f0; t.ovf1 = f1;
    return t;
  endfunction

  vec_t vt [19];

  initial begin
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h3F800000, 0, 0, 1, 1, 0, 0);
    vt[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[5]  = mk(1, 1, 1, 0, 5'd2, 32'h10, 5'd0, 32'hA, 32'h4, 32'hB, 3, 3, 0, 0);
    vt[6]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0);
    vt[7]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    vt[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[9]  = mk(1, 0, 0, 0, 5'd1, 32'd1, 0, 0, 0, 0, 1, 1, 0, 0);
    vt[10] = mk(1, 0, 0, 0, 5'd1, 32'd2, 0, 0, 0, 0, 2, 2, 0, 0);
    vt[11] = mk(1, 0, 0, 0, 5'd1, 32'd3, 0, 0, 0, 0, 3, 3, 0, 0);
    vt[12] = mk(1, 0, 0, 0, 5'd1, 32'd4, 0, 0, 0, 0, 4, 4, 0, 0);
    vt[13] = mk(1, 0, 0, 0, 5'd1, 32'd5, 0, 0, 0, 0, 4, 4, 1, 1);
    vt[14] = mk(1, 0, 0, 0, 5'd1, 32'd6, 0, 0, 0, 0, 4, 4, 1, 1);
    vt[15] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3, 1, 1);
    vt[16] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 2, 1, 1);
    vt[17] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    vt[18] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    do_reset();

    for (int r = 0; r < 19; r++) begin
      set_in(vt[r].g, vt[r].f, vt[r].m, vt[r].rd, vt[r].gi, vt[r].gd,
             vt[r].fi, vt[r].fd, vt[r].ma, vt[r].md);
      step();
      chk($sformatf("row%0d u0 count", r), 64'(n0), 64'(vt[r].cnt0));
      chk($sformatf("row%0d u1 count", r), 64'(n1), 64'(vt[r].cnt1));
      chk($sformatf("row%0d u0 overflow", r), 64'(o0), 64'(vt[r].ovf0));
      chk($sformatf("row%0d u1 overflow", r), 64'(o1), 64'(vt[r].ovf1));
      if (r == 3) chk("lwc1 stamp", 64'(c0), 64'd3);
      if (r == 14) begin
        chk("nowrap head oldest", 64'(d0), 64'd1);
        chk("wrap head oldest", 64'(d1), 64'd3);
      end
    end

    // Full buffer with simultaneous pop and push.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 0, 5'd3, 32'h21 + 32'(i), 0, 0, 0, 0);
      step();
    end
    set_in(1, 0, 0, 1, 5'd3, 32'h25, 0, 0, 0, 0);
    step();
    chk("full pop+push u0 overflow", 64'(o0), 64'd0);
    chk("full pop+push u0 count", 64'(n0), 64'd4);
    set_in(1, 1, 1, 1, 5'd4, 32'h26, 5'd5, 32'h27, 32'h100, 32'h28);
    step();
    chk("full pop+triple u0 overflow", 64'(o0), 64'd1);
    chk("full pop+triple u1 overflow", 64'(o1), 64'd1);

    // Capture disable leaves the buffer untouched.
    en = 1'b0;
    set_in(1, 0, 0, 0, 5'd6, 32'h99, 0, 0, 0, 0);
    step();
    chk("en=0 u0 count", 64'(n0), 64'd4);
    en = 1'b1;

    // Asynchronous reset between edges with entries pending.
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step();
    chk("pre-reset u0 count", 64'(n0), 64'd3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst u0 count", 64'(n0), 64'd0);
    chk("async rst u0 rd_valid", 64'(v0), 64'd0);
    chk("async rst u0 overflow", 64'(o0), 64'd0);

    // Cycle budget on the deep instance.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 0, 0, 5'd7, 32'(i), 0, 0, 0, 0);
      step();
    end
    chk("budget u2 count", 64'(n2), HALT_EN ? 64'd6 : 64'd10);
    chk("budget u2 halted", 64'(h2), 64'(HALT_EN));
    chk("budget u2 first stamp", 64'(c2), 64'd0);
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("budget drain u2 count", 64'(n2), HALT_EN ? 64'd4 : 64'd8);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("budget rst u2 halted", 64'(h2), 64'd0);
    chk("budget rst u2 count", 64'(n2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
